// File: rtl/accum_pkg.sv
// Shared types and defaults for the accumulator sequencer.
package accum_pkg;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/accum_sequencer_rise_detect.sv
// Rising-edge detector. The delayed copy resets high so that a level already
// asserted when reset is released is not taken as an edge.
module rise_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic In,
    output logic Edge
);
    logic in_q;

    always_ff @(posedge Clk) begin
        if (Reset) in_q <= 1'b1;
        else       in_q <= In;
    end

    assign Edge = In & ~in_q;
endmodule

// File: rtl/accum_sequencer.sv
// Accumulator sequencer: turns Run/Clear levels into register load/clear
// strobes for Count back-to-back accumulate steps, with a sticky overflow flag.
//   state | meaning
//   IDLE  | waiting for a Run rising edge
//   ADD   | Load asserted every cycle, Rem counts down to zero
//   HOLD  | sequence finished, Done shown until Run is released
module accum_sequencer
    import accum_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Clear,
    input  logic [CNT_W-1:0] Count,
    input  logic             CO,
    output logic             Load,
    output logic             Clr,
    output logic             Busy,
    output logic             Done,
    output logic             Ovf,
    output logic [CNT_W-1:0] Rem
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic             start;

    rise_detect u_run_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .In    (Run),
        .Edge  (start)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        Load    = (state_q == ADD) && !Clear;
        Clr     = Clear;
        Busy    = (state_q == ADD);
        Done    = (state_q == HOLD);
        ovf_d   = ovf_q | (Load & CO);

        if (Clear) begin
            state_d = IDLE;
            rem_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (Count != '0) begin
                            rem_d   = Count;
                            state_d = ADD;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
                ADD: begin
                    // Saturate at zero so Rem can never wrap.
                    rem_d = (rem_q != '0) ? rem_q - 1'b1 : '0;
                    if (rem_q <= CNT_W'(1)) state_d = HOLD;
                end
                HOLD: begin
                    if (!Run) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign Ovf = ovf_q;
    assign Rem = rem_q;
endmodule

// File: tb/tb_accum_sequencer.sv
// Directed vector bench for accum_sequencer: a per-cycle table of inputs and
// expected outputs, plus hand-written sequences for long runs and mid-run reset.
module tb_accum_sequencer;
    logic       clk = 1'b0;
    logic       reset, run, clear, co;
    logic [3:0] count;
    logic       load, clr, busy, done, ovf;
    logic [3:0] rem;

    int n_vec  = 0;
    int n_miss = 0;

    accum_sequencer #(.CNT_W(4)) dut (
        .Clk   (clk),
        .Reset (reset),
        .Run   (run),
        .Clear (clear),
        .Count (count),
        .CO    (co),
        .Load  (load),
        .Clr   (clr),
        .Busy  (busy),
        .Done  (done),
        .Ovf   (ovf),
        .Rem   (rem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       clear;
        logic [3:0] count;
        logic       co;
        logic       load;
        logic       clr;
        logic       busy;
        logic       done;
        logic       ovf;
        logic [3:0] rem;
    } vec_t;

    vec_t vq[$];

    function automatic void v(input logic r, input logic c, input logic [3:0] n,
                              input logic k, input logic l, input logic cl,
                              input logic b, input logic d, input logic o,
                              input logic [3:0] rm);
        vec_t t;
        t.run = r; t.clear = c; t.count = n; t.co = k;
        t.load = l; t.clr = cl; t.busy = b; t.done = d; t.ovf = o; t.rem = rm;
        vq.push_back(t);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        check({tag, ".Load"}, int'(load), int'(e.load));
        check({tag, ".Clr"},  int'(clr),  int'(e.clr));
        check({tag, ".Busy"}, int'(busy), int'(e.busy));
        check({tag, ".Done"}, int'(done), int'(e.done));
        check({tag, ".Ovf"},  int'(ovf),  int'(e.ovf));
        check({tag, ".Rem"},  int'(rem),  int'(e.rem));
    endtask

    int loads;
    int first_done;

    initial begin
        //    run clr cnt co | load clr busy done ovf rem
        // Run held high through and after reset: no start.
        v(1, 0, 3, 0,  0, 0, 0, 0, 0, 0);
        v(1, 0, 3, 0,  0, 0, 0, 0, 0, 0);
        v(1, 0, 3, 0,  0, 0, 0, 0, 0, 0);
        v(1, 0, 3, 0,  0, 0, 0, 0, 0, 0);
        v(1, 0, 3, 0,  0, 0, 0, 0, 0, 0);
        v(0, 0, 3, 0,  0, 0, 0, 0, 0, 0);
        // Count=3: three loads, Run release ignored, then HOLD and IDLE.
        v(1, 0, 3, 0,  0, 0, 0, 0, 0, 0);
        v(1, 0, 3, 0,  1, 0, 1, 0, 0, 3);
        v(0, 0, 3, 0,  1, 0, 1, 0, 0, 2);
        v(0, 0, 3, 0,  1, 0, 1, 0, 0, 1);
        v(0, 0, 3, 0,  0, 0, 0, 1, 0, 0);
        v(0, 0, 3, 0,  0, 0, 0, 0, 0, 0);
        // Count=0: straight to HOLD.
        v(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
        v(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        // Count=4, carry on 3rd load; Ovf sticky through a second run.
        v(1, 0, 4, 0,  0, 0, 0, 0, 0, 0);
        v(1, 0, 4, 0,  1, 0, 1, 0, 0, 4);
        v(1, 0, 4, 0,  1, 0, 1, 0, 0, 3);
        v(1, 0, 4, 1,  1, 0, 1, 0, 0, 2);
        v(1, 0, 4, 0,  1, 0, 1, 0, 1, 1);
        v(1, 0, 4, 1,  0, 0, 0, 1, 1, 0);
        v(0, 0, 4, 0,  0, 0, 0, 1, 1, 0);
        v(0, 0, 1, 0,  0, 0, 0, 0, 1, 0);
        v(1, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        v(0, 0, 1, 0,  1, 0, 1, 0, 1, 1);
        v(0, 0, 1, 0,  0, 0, 0, 1, 1, 0);
        v(0, 1, 1, 0,  0, 1, 0, 0, 1, 0);
        v(0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        // Count=5, Clear on 2nd ADD cycle (CO high must not set Ovf).
        v(1, 0, 5, 0,  0, 0, 0, 0, 0, 0);
        v(1, 0, 5, 0,  1, 0, 1, 0, 0, 5);
        v(1, 1, 5, 1,  0, 1, 1, 0, 0, 4);
        v(1, 0, 5, 0,  0, 0, 0, 0, 0, 0);
        v(0, 0, 5, 0,  0, 0, 0, 0, 0, 0);
        // Start edge coincident with Clear is discarded.
        v(1, 1, 3, 0,  0, 1, 0, 0, 0, 0);
        v(1, 0, 3, 0,  0, 0, 0, 0, 0, 0);
        v(1, 0, 3, 0,  0, 0, 0, 0, 0, 0);
        v(0, 0, 3, 0,  0, 0, 0, 0, 0, 0);

        reset = 1'b1; run = 1'b1; clear = 1'b0; co = 1'b0; count = 4'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("reset.Load", int'(load), 0);
        check("reset.Clr",  int'(clr),  0);
        check("reset.Busy", int'(busy), 0);
        check("reset.Done", int'(done), 0);
        check("reset.Ovf",  int'(ovf),  0);
        check("reset.Rem",  int'(rem),  0);

        foreach (vq[i]) begin
            @(negedge clk);
            run = vq[i].run; clear = vq[i].clear; count = vq[i].count; co = vq[i].co;
            #2;
            check_all($sformatf("vec%0d", i), vq[i]);
        end

        // Count=15 with Run held and Count toggled mid-sequence.
        @(negedge clk);
        run = 1'b1; clear = 1'b0; co = 1'b0; count = 4'd15;
        #2;
        check("max.idle_busy", int'(busy), 0);
        loads = 0; first_done = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            count = 4'(i * 7);
            #2;
            if (i == 0) check("max.rem_first", int'(rem), 15);
            if (load) loads++;
            if (done && first_done < 0) first_done = i;
        end
        check("max.loads", loads, 15);
        check("max.first_done", first_done, 15);
        check("max.hold_done", int'(done), 1);
        @(negedge clk);
        run = 1'b0;
        #2;
        check("max.release_done", int'(done), 1);
        @(negedge clk);
        #2;
        check("max.idle_done", int'(done), 0);
        check("max.idle_busy2", int'(busy), 0);

        // Reset mid-sequence after a carry: IDLE, Ovf and Rem cleared.
        @(negedge clk);
        run = 1'b1; count = 4'd5; co = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("rstmid.busy", int'(busy), 1);
        check("rstmid.ovf_set", int'(ovf), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; run = 1'b0; co = 1'b0;
        #2;
        check("rstmid.load", int'(load), 0);
        check("rstmid.busy_after", int'(busy), 0);
        check("rstmid.ovf", int'(ovf), 0);
        check("rstmid.rem", int'(rem), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
